// File: rtl/cache_sa.sv
// cache_sa: N-way set-associative write-back/write-allocate cache with true-LRU
// replacement and a full flush, between the core load/store port and word-wide memory.
module cache_sa #(
    parameter int TOTAL_ADDR_W  = 18,
    parameter int OFFSET_ADDR_W = 4,
    parameter int IDX_ADDR_W    = 5,
    parameter int WAYS          = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [TOTAL_ADDR_W-1:0] i_ADDR,
    input  logic [31:0]             i_WDATA,
    input  logic [3:0]              i_BMASK,
    input  logic                    i_WREN,
    input  logic                    i_VALID,
    output logic                    o_READY,
    output logic [31:0]             o_RDATA,
    input  logic                    i_FLUSH,
    output logic                    o_FLUSH_DONE,
    output logic [TOTAL_ADDR_W-1:0] o_mem_ADDR,
    output logic [31:0]             o_mem_WDATA,
    output logic [3:0]              o_mem_BMASK,
    output logic                    o_mem_WREN,
    input  logic [31:0]             i_mem_RDATA,
    output logic                    o_mem_VALID,
    input  logic                    i_mem_READY
);
    localparam int TAG_W = TOTAL_ADDR_W - IDX_ADDR_W - OFFSET_ADDR_W - 2;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int SETS  = 1 << IDX_ADDR_W;
    localparam int WORDS = 1 << OFFSET_ADDR_W;
    localparam logic [WAY_W-1:0] OLDEST = WAY_W'(WAYS - 1);

    typedef enum logic [1:0] {IDLE, WRITE_BACK, FETCH, FLUSH} state_t;
    state_t state, state_n;

    logic             vld   [WAYS][SETS];
    logic             dirty [WAYS][SETS];
    logic [TAG_W-1:0] tag   [WAYS][SETS];
    logic [WAY_W-1:0] age   [WAYS][SETS];
    logic [31:0]      data  [WAYS][SETS][WORDS];

    logic [OFFSET_ADDR_W-1:0] beat;
    logic [WAY_W-1:0]         victim, fl_way, hit_way, vic_way, wb_way, touch_way;
    logic [TAG_W-1:0]         m_tag, req_tag;
    logic [IDX_ADDR_W-1:0]    m_set, fl_set, req_set, wb_set, touch_set;
    logic [OFFSET_ADDR_W-1:0] req_off;
    logic hit, hs, mem_fire, last_beat, fl_dirty, fl_last, fl_line_done, fill_done, touch;
    logic unused;

    assign req_tag = i_ADDR[TOTAL_ADDR_W-1 -: TAG_W];
    assign req_set = i_ADDR[OFFSET_ADDR_W+2 +: IDX_ADDR_W];
    assign req_off = i_ADDR[2 +: OFFSET_ADDR_W];
    assign unused  = ^i_ADDR[1:0];

    // Victim: lowest-numbered invalid way wins over the LRU way.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        vic_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (vld[w][req_set] && tag[w][req_set] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (age[w][req_set] == OLDEST) vic_way = WAY_W'(w);
        end
        for (int w = WAYS - 1; w >= 0; w--)
            if (!vld[w][req_set]) vic_way = WAY_W'(w);
    end

    assign fl_dirty     = vld[fl_way][fl_set] & dirty[fl_way][fl_set];
    assign fl_last      = (&fl_set) && fl_way == OLDEST;
    assign last_beat    = &beat;
    assign o_READY      = state == IDLE && hit && !i_FLUSH;
    assign hs           = i_VALID & o_READY;
    assign o_mem_VALID  = state == WRITE_BACK || state == FETCH || (state == FLUSH && fl_dirty);
    assign o_mem_WREN   = state == WRITE_BACK || (state == FLUSH && fl_dirty);
    assign mem_fire     = o_mem_VALID & i_mem_READY;
    assign fill_done    = state == FETCH && mem_fire && last_beat;
    assign fl_line_done = state == FLUSH && (!fl_dirty || (mem_fire && last_beat));
    assign touch        = hs | fill_done;
    assign touch_way    = fill_done ? victim : hit_way;
    assign touch_set    = fill_done ? m_set : req_set;
    assign wb_way       = state == FLUSH ? fl_way : victim;
    assign wb_set       = state == FLUSH ? fl_set : m_set;
    assign o_RDATA      = hit ? data[hit_way][req_set][req_off] : '0;
    assign o_mem_ADDR   = state == FETCH ? {m_tag, m_set, beat, 2'b00}
                                         : {tag[wb_way][wb_set], wb_set, beat, 2'b00};
    assign o_mem_WDATA  = data[wb_way][wb_set][beat];
    assign o_mem_BMASK  = 4'hF;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:
                if (i_FLUSH) state_n = FLUSH;
                else if (i_VALID && !hit)
                    state_n = (vld[vic_way][req_set] && dirty[vic_way][req_set]) ? WRITE_BACK : FETCH;
            WRITE_BACK: if (mem_fire && last_beat) state_n = FETCH;
            FETCH:      if (fill_done) state_n = IDLE;
            FLUSH:      if (fl_line_done && fl_last) state_n = IDLE;
            default:    state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            beat         <= '0;
            victim       <= '0;
            m_tag        <= '0;
            m_set        <= '0;
            fl_set       <= '0;
            fl_way       <= '0;
            o_FLUSH_DONE <= 1'b0;
            for (int w = 0; w < WAYS; w++)
                for (int s = 0; s < SETS; s++) begin
                    vld[w][s]   <= 1'b0;
                    dirty[w][s] <= 1'b0;
                    tag[w][s]   <= '0;
                    age[w][s]   <= WAY_W'(w);
                end
        end else begin
            state        <= state_n;
            beat         <= state_n != state ? '0 : mem_fire ? beat + OFFSET_ADDR_W'(1) : beat;
            o_FLUSH_DONE <= state == FLUSH && state_n == IDLE;
            if (state == IDLE && i_VALID && !hit && !i_FLUSH) begin
                victim <= vic_way;
                m_tag  <= req_tag;
                m_set  <= req_set;
            end
            if (hs && i_WREN) dirty[hit_way][req_set] <= 1'b1;
            if (state == WRITE_BACK && mem_fire && last_beat) dirty[victim][m_set] <= 1'b0;
            if (fill_done) begin
                vld[victim][m_set]   <= 1'b1;
                dirty[victim][m_set] <= 1'b0;
                tag[victim][m_set]   <= m_tag;
            end
            // Touched way becomes MRU; only ways younger than it age.
            if (touch)
                for (int w = 0; w < WAYS; w++)
                    age[w][touch_set] <= WAY_W'(w) == touch_way ? '0 :
                                         age[w][touch_set] < age[touch_way][touch_set] ?
                                         age[w][touch_set] + WAY_W'(1) : age[w][touch_set];
            if (fl_line_done) begin
                vld[fl_way][fl_set]   <= 1'b0;
                dirty[fl_way][fl_set] <= 1'b0;
                fl_way                <= fl_way == OLDEST ? '0 : fl_way + WAY_W'(1);
                if (fl_way == OLDEST) fl_set <= fl_set + IDX_ADDR_W'(1);
                if (fl_last)
                    for (int w = 0; w < WAYS; w++)
                        for (int s = 0; s < SETS; s++)
                            age[w][s] <= WAY_W'(w);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (hs && i_WREN)
            for (int b = 0; b < 4; b++)
                if (i_BMASK[b]) data[hit_way][req_set][req_off][8*b +: 8] <= i_WDATA[8*b +: 8];
        if (state == FETCH && mem_fire) data[victim][m_set][beat] <= i_mem_RDATA;
    end
endmodule

// File: tb/tb_cache_sa.sv
// tb_cache_sa: directed and random checks of cache_sa against a per-way LRU cache model
// plus a golden memory image of what the core must observe.
module tb_cache_sa;
    localparam int WAYS = 2;

    logic        clk = 1'b0;
    logic        i_rst_n, i_WREN, i_VALID, i_FLUSH, i_mem_READY;
    logic [17:0] i_ADDR;
    logic [31:0] i_WDATA, i_mem_RDATA;
    logic [3:0]  i_BMASK;
    logic        o_READY, o_FLUSH_DONE, o_mem_WREN, o_mem_VALID;
    logic [31:0] o_RDATA, o_mem_WDATA;
    logic [17:0] o_mem_ADDR;
    logic [3:0]  o_mem_BMASK;

    cache_sa #(.WAYS(WAYS)) dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_ADDR(i_ADDR), .i_WDATA(i_WDATA), .i_BMASK(i_BMASK),
        .i_WREN(i_WREN), .i_VALID(i_VALID), .o_READY(o_READY), .o_RDATA(o_RDATA),
        .i_FLUSH(i_FLUSH), .o_FLUSH_DONE(o_FLUSH_DONE), .o_mem_ADDR(o_mem_ADDR),
        .o_mem_WDATA(o_mem_WDATA), .o_mem_BMASK(o_mem_BMASK), .o_mem_WREN(o_mem_WREN),
        .i_mem_RDATA(i_mem_RDATA), .o_mem_VALID(o_mem_VALID), .i_mem_READY(i_mem_READY)
    );

    initial forever #5 clk = ~clk;

    logic [31:0] mem [65536];
    logic [31:0] gm  [65536];
    assign i_mem_RDATA = mem[o_mem_ADDR[17:2]];
    always @(posedge clk)
        if (o_mem_VALID && i_mem_READY && o_mem_WREN) mem[o_mem_ADDR[17:2]] <= o_mem_WDATA;

    int rdy_pct = 100;
    initial begin
        i_mem_READY = 1'b0;
        forever begin
            @(posedge clk);
            #1 i_mem_READY = $urandom_range(99) < rdy_pct;
        end
    end

    int tests = 0, fails = 0, wbeats = 0, rbeats = 0, dones = 0;
    logic [31:0] exp_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: valid/dirty/tag per physical way, LRU order as a list of way numbers (MRU first).
    bit          mv  [32][WAYS];
    bit          md  [32][WAYS];
    int          mt  [32][WAYS];
    int          ord [32][WAYS];
    logic [17:0] eq_addr [$];
    bit          eq_wr   [$];
    logic [31:0] eq_data [$];

    function automatic void model_reset();
        for (int s = 0; s < 32; s++)
            for (int w = 0; w < WAYS; w++) begin
                mv[s][w] = 0;
                md[s][w] = 0;
                ord[s][w] = w;
            end
    endfunction

    function automatic void touch(int s, int w);
        int p = 0;
        for (int i = 0; i < WAYS; i++) if (ord[s][i] == w) p = i;
        for (int i = p; i > 0; i--) ord[s][i] = ord[s][i-1];
        ord[s][0] = w;
    endfunction

    function automatic void push_line(int t, int s, bit wr);
        logic [17:0] ad;
        for (int b = 0; b < 16; b++) begin
            ad = 18'(t * 2048 + s * 64 + b * 4);
            eq_addr.push_back(ad);
            eq_wr.push_back(wr);
            eq_data.push_back(gm[ad[17:2]]);
        end
    endfunction

    function automatic bit model_access(logic [17:0] a, bit wr, logic [31:0] wd, logic [3:0] bm);
        int s = int'(a[10:6]);
        int t = int'(a[17:11]);
        int w = -1;
        for (int i = 0; i < WAYS; i++) if (mv[s][i] && mt[s][i] == t) w = i;
        model_access = w >= 0;
        if (w < 0) begin
            w = ord[s][WAYS-1];
            for (int i = WAYS - 1; i >= 0; i--) if (!mv[s][i]) w = i;
            if (mv[s][w] && md[s][w]) push_line(mt[s][w], s, 1'b1);
            push_line(t, s, 1'b0);
            mv[s][w] = 1;
            md[s][w] = 0;
            mt[s][w] = t;
        end
        touch(s, w);
        if (wr) begin
            md[s][w] = 1;
            for (int b = 0; b < 4; b++) if (bm[b]) gm[a[17:2]][8*b +: 8] = wd[8*b +: 8];
        end
    endfunction

    function automatic void model_flush();
        for (int s = 0; s < 32; s++)
            for (int w = 0; w < WAYS; w++) begin
                if (mv[s][w] && md[s][w]) push_line(mt[s][w], s, 1'b1);
                mv[s][w] = 0;
                md[s][w] = 0;
                ord[s][w] = w;
            end
    endfunction

    // Compare process: read data on every read handshake, every accepted memory beat.
    initial begin
        logic [17:0] ea;
        bit          ew;
        logic [31:0] ed;
        forever begin
            @(negedge clk);
            if (i_rst_n) begin
                if (o_FLUSH_DONE) dones++;
                if (i_VALID && o_READY && !i_WREN) chk("rdata", o_RDATA, exp_rd);
                if (o_mem_VALID && i_mem_READY) begin
                    if (o_mem_WREN) wbeats++; else rbeats++;
                    if (eq_addr.size() == 0) chk("beat_unexpected", 32'(o_mem_ADDR), 32'hFFFF_FFFF);
                    else begin
                        ea = eq_addr.pop_front();
                        ew = eq_wr.pop_front();
                        ed = eq_data.pop_front();
                        chk("beat_addr", 32'(o_mem_ADDR), 32'(ea));
                        chk("beat_wren", 32'(o_mem_WREN), 32'(ew));
                        chk("beat_bmask", 32'(o_mem_BMASK), 32'hF);
                        if (ew) chk("beat_wdata", o_mem_WDATA, ed);
                    end
                end
            end
        end
    end

    task automatic req(input logic [17:0] a, input bit wr, input logic [31:0] wd,
                       input logic [3:0] bm, output int lat, output logic [31:0] rd);
        bit h;
        @(posedge clk);
        #1;
        exp_rd = gm[a[17:2]];
        h = model_access(a, wr, wd, bm);
        i_ADDR = a;
        i_WREN = wr;
        i_WDATA = wd;
        i_BMASK = bm;
        i_VALID = 1'b1;
        lat = 0;
        forever begin
            @(negedge clk);
            if (o_READY) break;
            lat++;
            if (lat > 3000) begin
                chk("req_timeout", 32'(lat), 32'd0);
                break;
            end
        end
        rd = o_RDATA;
        chk("hit_pred", 32'(lat == 0), 32'(h));
        @(posedge clk);
        #1 i_VALID = 1'b0;
    endtask

    task automatic do_flush();
        int n = 0;
        int d0 = dones;
        @(posedge clk);
        #1;
        model_flush();
        i_FLUSH = 1'b1;
        @(posedge clk);
        #1 i_FLUSH = 1'b0;
        while (dones == d0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("flush_done_pulses", 32'(dones - d0), 32'd1);
        chk("flush_beats_left", 32'(eq_addr.size()), 32'd0);
    endtask

    initial begin
        int lat, w0, r0, n, nmis;
        logic [31:0] rd;
        logic [17:0] a;
        #800000;
        $display("FAIL watchdog: run exceeded cycle limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, w0, r0, n, nmis;
        logic [31:0] rd;
        logic [17:0] a;
        i_rst_n = 1'b0; i_VALID = 1'b0; i_FLUSH = 1'b0; i_WREN = 1'b0;
        i_ADDR = '0; i_WDATA = '0; i_BMASK = '0;
        for (int i = 0; i < 65536; i++) mem[i] = $urandom;
        mem[16] = 32'hCAFE_0040;
        gm = mem;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_valid", 32'(o_mem_VALID), 32'd0);
        chk("rst_ready", 32'(o_READY), 32'd0);
        chk("rst_rdata", o_RDATA, 32'd0);
        chk("rst_flush_done", 32'(o_FLUSH_DONE), 32'd0);
        @(posedge clk);
        #1 i_rst_n = 1'b1;

        req(18'h00040, 1'b0, '0, '0, lat, rd);
        chk("cold_latency", 32'(lat), 32'd17);
        chk("cold_data", rd, 32'hCAFE_0040);

        req(18'h00044, 1'b1, 32'h1122_3344, 4'hF, lat, rd);
        chk("wr_hit_latency", 32'(lat), 32'd0);
        req(18'h00044, 1'b1, 32'hDEAD_BEEF, 4'b0011, lat, rd);
        chk("merge_latency", 32'(lat), 32'd0);
        req(18'h00044, 1'b0, '0, '0, lat, rd);
        chk("merge_data", rd, 32'h1122_BEEF);

        req(18'h00000, 1'b0, '0, '0, lat, rd);
        req(18'h00800, 1'b0, '0, '0, lat, rd);
        req(18'h00000, 1'b0, '0, '0, lat, rd);
        req(18'h01000, 1'b0, '0, '0, lat, rd);
        req(18'h00000, 1'b0, '0, '0, lat, rd);
        chk("lru_A_hit", 32'(lat), 32'd0);
        req(18'h00800, 1'b0, '0, '0, lat, rd);
        chk("lru_B_evicted", 32'(lat != 0), 32'd1);

        req(18'h00080, 1'b1, 32'h0BAD_F00D, 4'hF, lat, rd);
        req(18'h00880, 1'b0, '0, '0, lat, rd);
        w0 = wbeats; r0 = rbeats;
        req(18'h01080, 1'b0, '0, '0, lat, rd);
        chk("dirty_evict_wbeats", 32'(wbeats - w0), 32'd16);
        chk("dirty_evict_rbeats", 32'(rbeats - r0), 32'd16);
        w0 = wbeats; r0 = rbeats;
        req(18'h01880, 1'b0, '0, '0, lat, rd);
        chk("clean_evict_wbeats", 32'(wbeats - w0), 32'd0);
        chk("clean_evict_rbeats", 32'(rbeats - r0), 32'd16);

        rdy_pct = 60;
        do_flush();
        req(18'h000C0, 1'b1, 32'h1234_5678, 4'hF, lat, rd);
        req(18'h00100, 1'b1, 32'h9ABC_DEF0, 4'b1010, lat, rd);
        w0 = wbeats;
        do_flush();
        chk("flush_wbeats", 32'(wbeats - w0), 32'd32);
        req(18'h000C0, 1'b0, '0, '0, lat, rd);
        chk("post_flush_miss0", 32'(lat != 0), 32'd1);
        req(18'h00100, 1'b0, '0, '0, lat, rd);
        chk("post_flush_miss1", 32'(lat != 0), 32'd1);
        req(18'h00044, 1'b0, '0, '0, lat, rd);
        chk("post_flush_miss2", 32'(lat != 0), 32'd1);

        rdy_pct = 100;
        @(posedge clk);
        #1;
        void'(model_access(18'h02000, 1'b0, '0, '0));
        i_ADDR = 18'h02000; i_WREN = 1'b0; i_VALID = 1'b1;
        n = 0;
        while (!(o_mem_VALID && o_mem_ADDR == 18'h0201C) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rst_beat7_found", 32'(n < 100), 32'd1);
        i_rst_n = 1'b0;
        i_VALID = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_mem_valid", 32'(o_mem_VALID), 32'd0);
        eq_addr.delete(); eq_wr.delete(); eq_data.delete();
        model_reset();
        gm = mem;
        @(posedge clk);
        #1 i_rst_n = 1'b1;
        req(18'h02000, 1'b0, '0, '0, lat, rd);
        chk("rst_refetch_miss", 32'(lat != 0), 32'd1);

        rdy_pct = 70;
        repeat (400) begin
            if ($urandom_range(39) == 0) do_flush();
            else begin
                a = {7'($urandom_range(3)), 5'($urandom_range(3)), 4'($urandom), 2'b00};
                req(a, 1'($urandom), $urandom, 4'($urandom), lat, rd);
            end
        end
        do_flush();
        nmis = 0;
        for (int i = 0; i < 65536; i++) if (mem[i] !== gm[i]) nmis++;
        chk("final_memory_image", 32'(nmis), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
